tmds_encoder: RTL



---
 rtl/tmds_encoder.sv | 100 ++++++++++
 1 files changed

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: transition-minimising stage followed by a
// DC-balancing stage with running disparity and control-period symbols.
module tmds_encoder (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic [7:0]        data_in,
  input  logic [1:0]        control_in,
  input  logic              ve_in,
  output logic [9:0]        tmds_out,
  output logic signed [4:0] disparity_out
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned QM_W   = DATA_W + 1;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EXT_W  = CNT_W + 1;
  localparam int unsigned POP_W  = 4;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  logic [POP_W-1:0] n1_c;
  logic             use_xnor_c;
  logic [QM_W-1:0]  qm_c;
  logic [QM_W-1:0]  qm_q;
  logic             ve_q;
  logic [1:0]       ctrl_q;

  // Stage 1: choose XOR/XNOR chaining to minimise transitions
  always_comb begin
    n1_c = '0;
    for (int i = 0; i < DATA_W; i++) n1_c = n1_c + POP_W'(data_in[i]);
    use_xnor_c = (n1_c > 4'd4) || ((n1_c == 4'd4) && !data_in[0]);
    qm_c       = '0;
    qm_c[0]    = data_in[0];
    for (int i = 1; i < DATA_W; i++)
      qm_c[i] = use_xnor_c ? ~(qm_c[i-1] ^ data_in[i]) : (qm_c[i-1] ^ data_in[i]);
    qm_c[DATA_W] = ~use_xnor_c;
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      qm_q   <= '0;
      ve_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_c;
      ve_q   <= ve_in;
      ctrl_q <= control_in;
    end
  end

  logic [POP_W-1:0]        n1q_c;
  logic signed [EXT_W-1:0] diff_c;     // N1q - N0q
  logic signed [EXT_W-1:0] cnt_ext_c;
  logic signed [EXT_W-1:0] cnt_nx_c;
  logic [SYM_W-1:0]        sym_nx_c;

  // Stage 2: DC balance against the running disparity
  always_comb begin
    n1q_c = '0;
    for (int i = 0; i < DATA_W; i++) n1q_c = n1q_c + POP_W'(qm_q[i]);
    diff_c    = $signed(EXT_W'({n1q_c, 1'b0})) - 6'sd8;
    cnt_ext_c = EXT_W'(disparity_out);
    sym_nx_c  = CTRL_00;
    cnt_nx_c  = '0;
    if (!ve_q) begin
      case (ctrl_q)
        2'b00:   sym_nx_c = CTRL_00;
        2'b01:   sym_nx_c = CTRL_01;
        2'b10:   sym_nx_c = CTRL_10;
        default: sym_nx_c = CTRL_11;
      endcase
    end else if ((disparity_out == 5'sd0) || (diff_c == 6'sd0)) begin
      sym_nx_c = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_nx_c = qm_q[8] ? (cnt_ext_c + diff_c) : (cnt_ext_c - diff_c);
    end else if (((disparity_out > 5'sd0) && (diff_c > 6'sd0)) ||
                 ((disparity_out < 5'sd0) && (diff_c < 6'sd0))) begin
      sym_nx_c = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_nx_c = cnt_ext_c + (qm_q[8] ? 6'sd2 : 6'sd0) - diff_c;
    end else begin
      sym_nx_c = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_nx_c = cnt_ext_c + diff_c - (qm_q[8] ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      tmds_out      <= CTRL_00;
      disparity_out <= '0;
    end else begin
      tmds_out      <= sym_nx_c;
      disparity_out <= CNT_W'(cnt_nx_c);
    end
  end

endmodule
